// File: rtl/reg_universal_pkg.sv
// Shared mode encoding and mode-class helpers for the universal shift register
// family (per-bit cell and N-bit top).
package reg_universal_pkg;

  localparam logic [2:0] MANTENER      = 3'b000;
  localparam logic [2:0] CARGA         = 3'b001;
  localparam logic [2:0] DESP_DER      = 3'b010;
  localparam logic [2:0] DESP_IZQ      = 3'b011;
  localparam logic [2:0] ROT_DER       = 3'b100;
  localparam logic [2:0] ROT_IZQ       = 3'b101;
  localparam logic [2:0] DESP_ARIT_DER = 3'b110;
  localparam logic [2:0] LIMPIAR       = 3'b111;

  // Modes that advance the word-framing counter; rotations deliberately excluded.
  function automatic logic es_desplazamiento(input logic [2:0] m);
    return (m == DESP_DER) || (m == DESP_IZQ) || (m == DESP_ARIT_DER);
  endfunction

  function automatic logic reinicia_cuenta(input logic [2:0] m);
    return (m == CARGA) || (m == LIMPIAR);
  endfunction

endpackage

// File: rtl/reg_1bit_universal.sv
// One bit of the universal register: 8:1 next-value mux feeding a flop with
// synchronous reset and enable.
module reg_1bit_universal
  import reg_universal_pkg::*;
(
  input  logic       reloj,
  input  logic       reset,
  input  logic       habilita,
  input  logic [2:0] modo,
  input  logic       propio,
  input  logic       izq,
  input  logic       der,
  input  logic       paralelo,
  output logic       q
);

  logic siguiente;

  // izq is the more-significant neighbour, der the less-significant one.
  always_comb begin
    siguiente = propio;
    case (modo)
      MANTENER:      siguiente = propio;
      CARGA:         siguiente = paralelo;
      DESP_DER:      siguiente = izq;
      DESP_IZQ:      siguiente = der;
      ROT_DER:       siguiente = izq;
      ROT_IZQ:       siguiente = der;
      DESP_ARIT_DER: siguiente = izq;
      LIMPIAR:       siguiente = 1'b0;
      default:       siguiente = propio;
    endcase
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      q <= 1'b0;
    end else if (habilita) begin
      q <= siguiente;
    end
  end

endmodule

// File: rtl/reg_nbits_universal.sv
// N-bit universal register: N cells plus a saturating shift counter whose
// terminal value raises listo for serial word framing.
module reg_nbits_universal
  import reg_universal_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         reloj,
  input  logic         reset,
  input  logic         habilita,
  input  logic [2:0]   modo,
  input  logic [N-1:0] In,
  input  logic         ser_msb,
  input  logic         ser_lsb,
  output logic [N-1:0] An,
  output logic         sal_lsb,
  output logic         sal_msb,
  output logic         listo
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CUENTA_MAX = CW'(N);

  logic          izq_msb;
  logic          der_lsb;
  logic [N-1:0]  izq;
  logic [N-1:0]  der;
  logic [CW-1:0] cuenta;

  // Edge feeds: serial input, wrap-around bit, or replicated sign bit.
  always_comb begin
    izq_msb = An[N-1];
    case (modo)
      DESP_DER: izq_msb = ser_msb;
      ROT_DER:  izq_msb = An[0];
      default:  izq_msb = An[N-1];
    endcase
  end

  always_comb begin
    der_lsb = An[N-1];
    case (modo)
      DESP_IZQ: der_lsb = ser_lsb;
      default:  der_lsb = An[N-1];
    endcase
  end

  assign izq = {izq_msb, An[N-1:1]};
  assign der = {An[N-2:0], der_lsb};

  for (genvar i = 0; i < N; i++) begin : g_celda
    reg_1bit_universal u_celda (
      .reloj    (reloj),
      .reset    (reset),
      .habilita (habilita),
      .modo     (modo),
      .propio   (An[i]),
      .izq      (izq[i]),
      .der      (der[i]),
      .paralelo (In[i]),
      .q        (An[i])
    );
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      cuenta <= '0;
    end else if (habilita) begin
      if (reinicia_cuenta(modo)) begin
        cuenta <= '0;
      end else if (es_desplazamiento(modo) && (cuenta != CUENTA_MAX)) begin
        cuenta <= cuenta + CW'(1);
      end
    end
  end

  assign listo   = (cuenta == CUENTA_MAX);
  assign sal_lsb = An[0];
  assign sal_msb = An[N-1];

endmodule

// File: tb/tb_reg_nbits_universal.sv
// Directed checks of the 4-bit register plus a model-checked mode sweep at 8 bits.
module tb_reg_nbits_universal;

  localparam logic [2:0] MANTENER      = 3'b000;
  localparam logic [2:0] CARGA         = 3'b001;
  localparam logic [2:0] DESP_DER      = 3'b010;
  localparam logic [2:0] DESP_IZQ      = 3'b011;
  localparam logic [2:0] ROT_DER       = 3'b100;
  localparam logic [2:0] ROT_IZQ       = 3'b101;
  localparam logic [2:0] DESP_ARIT_DER = 3'b110;
  localparam logic [2:0] LIMPIAR       = 3'b111;

  logic       reloj = 1'b0;
  logic       reset, habilita, ser_msb, ser_lsb;
  logic [2:0] modo;
  logic [3:0] in4, an4;
  logic       sal_lsb4, sal_msb4, listo4;

  logic       reset8, habilita8, ser_msb8, ser_lsb8;
  logic [2:0] modo8;
  logic [7:0] in8, an8;
  logic       sal_lsb8, sal_msb8, listo8;

  int checks = 0;
  int errores = 0;

  always #5 reloj = ~reloj;

  reg_nbits_universal #(.N(4)) dut4 (
    .reloj(reloj), .reset(reset), .habilita(habilita), .modo(modo), .In(in4),
    .ser_msb(ser_msb), .ser_lsb(ser_lsb), .An(an4), .sal_lsb(sal_lsb4),
    .sal_msb(sal_msb4), .listo(listo4)
  );

  reg_nbits_universal #(.N(8)) dut8 (
    .reloj(reloj), .reset(reset8), .habilita(habilita8), .modo(modo8), .In(in8),
    .ser_msb(ser_msb8), .ser_lsb(ser_lsb8), .An(an8), .sal_lsb(sal_lsb8),
    .sal_msb(sal_msb8), .listo(listo8)
  );

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic flanco();
    @(posedge reloj);
    #1;
  endtask

  task automatic paso4(input logic [2:0] m, input logic sl, input logic [3:0] esp_an,
                       input logic esp_listo, input string tag);
    modo = m;
    ser_lsb = sl;
    flanco();
    chequear({tag, "_an"}, 32'(an4), 32'(esp_an));
    chequear({tag, "_listo"}, 32'(listo4), 32'(esp_listo));
  endtask

  logic [7:0] m_an;
  int         m_cnt;

  initial begin
    reset = 1'b1; habilita = 1'b1; modo = CARGA; in4 = 4'b1111; ser_msb = 1'b0; ser_lsb = 1'b0;
    reset8 = 1'b1; habilita8 = 1'b1; modo8 = MANTENER; in8 = '0; ser_msb8 = 1'b0; ser_lsb8 = 1'b0;
    flanco();
    chequear("rst_an", 32'(an4), 32'h0);
    chequear("rst_listo", 32'(listo4), 32'h0);

    reset = 1'b0;
    in4 = 4'b1011;
    paso4(CARGA, 1'b0, 4'b1011, 1'b0, "carga");
    chequear("carga_msb", 32'(sal_msb4), 32'h1);
    chequear("carga_lsb", 32'(sal_lsb4), 32'h1);
    ser_msb = 1'b0;
    paso4(DESP_DER, 1'b0, 4'b0101, 1'b0, "desp_der");
    paso4(ROT_IZQ, 1'b0, 4'b1010, 1'b0, "rot_izq");
    paso4(DESP_ARIT_DER, 1'b0, 4'b1101, 1'b0, "arit");
    ser_msb = 1'b1;
    paso4(DESP_DER, 1'b0, 4'b1110, 1'b0, "desp_der_ser1");
    paso4(ROT_DER, 1'b0, 4'b0111, 1'b0, "rot_der");

    // SIPO word: listo only after the fourth shift, stays on after a fifth
    paso4(LIMPIAR, 1'b0, 4'b0000, 1'b0, "limpiar");
    paso4(DESP_IZQ, 1'b1, 4'b0001, 1'b0, "sipo1");
    paso4(DESP_IZQ, 1'b0, 4'b0010, 1'b0, "sipo2");
    paso4(DESP_IZQ, 1'b1, 4'b0101, 1'b0, "sipo3");
    paso4(DESP_IZQ, 1'b1, 4'b1011, 1'b1, "sipo4");
    paso4(DESP_IZQ, 1'b0, 4'b0110, 1'b1, "sipo5");
    paso4(ROT_DER, 1'b0, 4'b0011, 1'b1, "rot_der_listo");
    paso4(MANTENER, 1'b1, 4'b0011, 1'b1, "mantener");

    // Enable dropped mid-word, including with LIMPIAR pending
    paso4(LIMPIAR, 1'b0, 4'b0000, 1'b0, "limpiar2");
    paso4(DESP_IZQ, 1'b1, 4'b0001, 1'b0, "hab_s1");
    paso4(DESP_IZQ, 1'b1, 4'b0011, 1'b0, "hab_s2");
    habilita = 1'b0;
    for (int i = 0; i < 3; i++) paso4(DESP_IZQ, 1'b1, 4'b0011, 1'b0, "hab_off");
    paso4(LIMPIAR, 1'b1, 4'b0011, 1'b0, "hab_off_limpiar");
    habilita = 1'b1;
    paso4(DESP_IZQ, 1'b0, 4'b0110, 1'b0, "hab_s3");
    paso4(DESP_IZQ, 1'b1, 4'b1101, 1'b1, "hab_s4");

    // Reset mid-word discards the partial count
    paso4(LIMPIAR, 1'b0, 4'b0000, 1'b0, "limpiar3");
    paso4(DESP_IZQ, 1'b1, 4'b0001, 1'b0, "rst_s1");
    paso4(DESP_IZQ, 1'b1, 4'b0011, 1'b0, "rst_s2");
    reset = 1'b1;
    paso4(DESP_IZQ, 1'b1, 4'b0000, 1'b0, "rst_mid");
    reset = 1'b0;
    paso4(DESP_IZQ, 1'b1, 4'b0001, 1'b0, "post_rst1");
    paso4(DESP_IZQ, 1'b1, 4'b0011, 1'b0, "post_rst2");
    paso4(DESP_IZQ, 1'b1, 4'b0111, 1'b0, "post_rst3");
    paso4(DESP_IZQ, 1'b1, 4'b1111, 1'b1, "post_rst4");
    paso4(LIMPIAR, 1'b0, 4'b0000, 1'b0, "limpiar_fin");

    // 8-bit sweep against a behavioural model
    m_an = '0;
    m_cnt = 0;
    reset8 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      modo8     = (c < 32) ? 3'(c % 8) : 3'($urandom_range(0, 7));
      in8       = 8'($urandom);
      ser_msb8  = 1'($urandom);
      ser_lsb8  = 1'($urandom);
      habilita8 = ($urandom_range(0, 9) != 0);
      reset8    = (c > 40) && ($urandom_range(0, 49) == 0);
      if (reset8) begin
        m_an = '0;
        m_cnt = 0;
      end else if (habilita8) begin
        case (modo8)
          CARGA:         begin m_an = in8; m_cnt = 0; end
          DESP_DER:      begin m_an = {ser_msb8, m_an[7:1]}; m_cnt++; end
          DESP_IZQ:      begin m_an = {m_an[6:0], ser_lsb8}; m_cnt++; end
          ROT_DER:       m_an = {m_an[0], m_an[7:1]};
          ROT_IZQ:       m_an = {m_an[6:0], m_an[7]};
          DESP_ARIT_DER: begin m_an = {m_an[7], m_an[7:1]}; m_cnt++; end
          LIMPIAR:       begin m_an = '0; m_cnt = 0; end
          default:       m_an = m_an;
        endcase
        if (m_cnt > 8) m_cnt = 8;
      end
      flanco();
      chequear("sweep_an", 32'(an8), 32'(m_an));
      chequear("sweep_listo", 32'(listo8), 32'(m_cnt == 8));
      chequear("sweep_sal", 32'({sal_msb8, sal_lsb8}), 32'({m_an[7], m_an[0]}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errores);
    $finish;
  end

endmodule
